ltc2308_emulator: RTL and testbench

Synthesizable responder for the LTC2308 4-wire serial ADC interface: it receives CONVST, SCK and SDI from our ADC controller and drives SDO exactly as the physical converter does. It is used for loopback on boards without the ADC populated and as the device model in controller benches. Analog inputs come from eight 12-bit digital channel values supplied by the surrounding design, for example a test pattern or a MIDI-driven waveform.

---
 rtl/ltc2308_pkg.sv | 67 ++++++
 rtl/ltc2308_emulator_edge_sync.sv | 33 +++
 rtl/ltc2308_emulator.sv | 158 +++++++++++++++
 tb/tb_ltc2308_emulator.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/ltc2308_pkg.sv
// Shared types, constants and the result-coding function for the LTC2308 emulator.
package ltc2308_pkg;

  localparam int RESULT_W = 12;
  localparam int CFG_W    = 6;
  localparam int NUM_CH   = 8;

  // Config word bit positions: [5]S/D [4]O/S [3]S1 [2]S0 [1]UNI [0]SLP
  localparam int CFG_SD  = 5;
  localparam int CFG_OS  = 4;
  localparam int CFG_S1  = 3;
  localparam int CFG_S0  = 2;
  localparam int CFG_UNI = 1;
  localparam int CFG_SLP = 0;

  // Single-ended ch0, unipolar
  localparam logic [CFG_W-1:0] CFG_RESET = 6'b100010;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    READY,
    SHIFT
  } state_t;

  // Pick one 12-bit channel out of the packed channel bus
  function automatic logic [RESULT_W-1:0] ch_pick(
    input logic [NUM_CH*RESULT_W-1:0] ch,
    input logic [2:0]                 sel
  );
    return ch[32'(sel)*RESULT_W +: RESULT_W];
  endfunction

  // Converter output code for a given config and channel snapshot.
  // Single-ended: channel {S1,S0,O/S}, straight binary (UNI) or offset binary.
  // Differential: pair {S1,S0}, O/S chooses which member is the + input;
  // the 13-bit difference is clamped (UNI) or saturated to 12-bit signed.
  function automatic logic [RESULT_W-1:0] ltc_result(
    input logic [NUM_CH*RESULT_W-1:0] ch,
    input logic [CFG_W-1:0]           cfg
  );
    logic [2:0]          pos_sel;
    logic [2:0]          neg_sel;
    logic [RESULT_W-1:0] pos_v;
    logic [RESULT_W-1:0] neg_v;
    logic signed [12:0]  diff;
    logic [RESULT_W-1:0] res;
    pos_sel = {cfg[CFG_S1], cfg[CFG_S0], cfg[CFG_OS]};
    neg_sel = {cfg[CFG_S1], cfg[CFG_S0], ~cfg[CFG_OS]};
    pos_v   = ch_pick(ch, pos_sel);
    neg_v   = ch_pick(ch, neg_sel);
    diff    = $signed({1'b0, pos_v}) - $signed({1'b0, neg_v});
    if (cfg[CFG_SD]) begin
      res = cfg[CFG_UNI] ? pos_v : (pos_v ^ 12'h800);
    end else if (cfg[CFG_UNI]) begin
      res = diff[12] ? 12'h000 : diff[11:0];
    end else if (diff > 13'sd2047) begin
      res = 12'h7FF;
    end else if (diff < -13'sd2048) begin
      res = 12'h800;
    end else begin
      res = diff[11:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/ltc2308_emulator_edge_sync.sv
// Two-flop synchronizer for an asynchronous pin plus a delayed copy for
// single-cycle rise/fall strobes.
module edge_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Synchronize the pin and keep last cycle's synchronized value
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign level_o = sync_q;
  assign rise_o  = sync_q & ~prev_q;
  assign fall_o  = ~sync_q & prev_q;

endmodule

// File: rtl/ltc2308_emulator.sv
// LTC2308 serial ADC responder: CONVST/SCK/SDI in, SDO out, with
// conversion timing, config capture and result coding of the real part.
module ltc2308_emulator
  import ltc2308_pkg::*;
#(
  parameter int CONV_CYCLES = 80
) (
  input  logic        clk_clk,
  input  logic        reset_reset,
  input  logic        adc_convst,
  input  logic        adc_sck,
  input  logic        adc_sdi,
  output logic        adc_sdo,
  output logic        adc_sdo_oe,
  input  logic [95:0] ch_value,
  output logic [5:0]  cfg_word,
  output logic [15:0] conv_count,
  output logic        err_early
);

  localparam int              CW       = $clog2(CONV_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_LOAD = CW'(CONV_CYCLES - 1);

  // Synchronized pin views
  logic convst_lvl, convst_rise, convst_fall_unused;
  logic sck_lvl_unused, sck_rise, sck_fall;
  logic sdi_lvl, sdi_rise_unused, sdi_fall_unused;

  edge_sync u_sync_convst (
    .clk_i   (clk_clk),
    .rst_i   (reset_reset),
    .d_i     (adc_convst),
    .level_o (convst_lvl),
    .rise_o  (convst_rise),
    .fall_o  (convst_fall_unused)
  );

  edge_sync u_sync_sck (
    .clk_i   (clk_clk),
    .rst_i   (reset_reset),
    .d_i     (adc_sck),
    .level_o (sck_lvl_unused),
    .rise_o  (sck_rise),
    .fall_o  (sck_fall)
  );

  edge_sync u_sync_sdi (
    .clk_i   (clk_clk),
    .rst_i   (reset_reset),
    .d_i     (adc_sdi),
    .level_o (sdi_lvl),
    .rise_o  (sdi_rise_unused),
    .fall_o  (sdi_fall_unused)
  );

  state_t              state_q;
  logic [CW-1:0]       cnt_q;
  logic [CFG_W-1:0]    cfg_q;
  logic [CFG_W-1:0]    pend_q;
  logic [RESULT_W-1:0] result_q;
  logic [3:0]          bit_cnt_q;
  logic [2:0]          cap_cnt_q;
  logic                sdo_q;
  logic                oe_q;
  logic [15:0]         count_q;
  logic                err_q;

  logic [CFG_W-1:0]    cfg_d;
  logic [RESULT_W-1:0] result_d;
  logic [CFG_W-1:0]    pend_d;
  logic                sdo_d;
  logic                start_conv;

  // SLP is held in cfg_word for software but never changes behaviour
  logic unused_slp;
  assign unused_slp = cfg_q[CFG_SLP];

  // Next-conversion config, its result, the SDI shift and the next SDO bit
  always_comb begin
    cfg_d = pend_q;
    // A frame that captured fewer than six SDI bits leaves the config alone
    if (state_q == SHIFT && cap_cnt_q != 3'(CFG_W)) cfg_d = cfg_q;
    result_d   = ltc_result(ch_value, cfg_d);
    pend_d     = {pend_q[CFG_W-2:0], sdi_lvl};
    sdo_d      = 1'b0;
    if (bit_cnt_q < 4'd11) sdo_d = result_q[4'd10 - bit_cnt_q];
    start_conv = convst_rise && (state_q == IDLE || state_q == SHIFT);
  end

  // Converter state machine with registered pin outputs
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      cfg_q     <= CFG_RESET;
      pend_q    <= CFG_RESET;
      result_q  <= '0;
      bit_cnt_q <= '0;
      cap_cnt_q <= '0;
      sdo_q     <= 1'b0;
      oe_q      <= 1'b0;
      count_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (start_conv) begin
        // CONVST wins over any SCK strobe in the same cycle
        state_q  <= CONV;
        cfg_q    <= cfg_d;
        pend_q   <= cfg_d;
        result_q <= result_d;
        cnt_q    <= CNT_LOAD;
        oe_q     <= 1'b0;
        sdo_q    <= 1'b0;
      end else begin
        case (state_q)
          IDLE: ;
          CONV: begin
            if (convst_rise) err_q <= 1'b1;
            if (cnt_q == '0) begin
              state_q <= READY;
              count_q <= count_q + 16'd1;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
          READY: begin
            if (!convst_lvl) begin
              state_q   <= SHIFT;
              oe_q      <= 1'b1;
              sdo_q     <= result_q[RESULT_W-1];
              bit_cnt_q <= '0;
              cap_cnt_q <= '0;
            end
          end
          SHIFT: begin
            if (sck_fall && bit_cnt_q < 4'd12) begin
              sdo_q     <= sdo_d;
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end
            if (sck_rise && cap_cnt_q < 3'(CFG_W)) begin
              pend_q    <= pend_d;
              cap_cnt_q <= cap_cnt_q + 3'd1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign adc_sdo    = sdo_q;
  assign adc_sdo_oe = oe_q;
  assign cfg_word   = cfg_q;
  assign conv_count = count_q;
  assign err_early  = err_q;

endmodule

// File: tb/tb_ltc2308_emulator.sv
// Drives the emulator as an ADC controller would and checks frames against
// an arithmetic model of the converter.
module tb_ltc2308_emulator;

  localparam int CONV = 80;
  localparam logic [5:0] DEF_CFG = 6'b100010;

  logic        clk_clk = 1'b0;
  logic        reset_reset = 1'b1;
  logic        adc_convst = 1'b0;
  logic        adc_sck = 1'b0;
  logic        adc_sdi = 1'b0;
  logic        adc_sdo;
  logic        adc_sdo_oe;
  logic [95:0] ch_value;
  logic [5:0]  cfg_word;
  logic [15:0] conv_count;
  logic        err_early;

  logic [11:0] ch [8];
  int          total = 0;
  int          bad = 0;
  logic [5:0]  m_cfg;
  logic [5:0]  m_next;
  int          m_count;

  always #5 clk_clk = ~clk_clk;

  always_comb begin
    ch_value = '0;
    for (int k = 0; k < 8; k++) ch_value[k*12 +: 12] = ch[k];
  end

  ltc2308_emulator #(.CONV_CYCLES(CONV)) dut (
    .clk_clk     (clk_clk),
    .reset_reset (reset_reset),
    .adc_convst  (adc_convst),
    .adc_sck     (adc_sck),
    .adc_sdi     (adc_sdi),
    .adc_sdo     (adc_sdo),
    .adc_sdo_oe  (adc_sdo_oe),
    .ch_value    (ch_value),
    .cfg_word    (cfg_word),
    .conv_count  (conv_count),
    .err_early   (err_early)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_clk);
    #1;
  endtask

  // Converter behaviour from the datasheet rules, in plain integers
  function automatic logic [11:0] ref_result(input logic [5:0] c);
    int s, os, v, p, m, d;
    s  = int'(c[3:2]);
    os = int'(c[4]);
    if (c[5]) begin
      v = ch[2*s + os];
      if (!c[1]) v = (v + 2048) % 4096;
    end else begin
      p = ch[2*s + os];
      m = ch[2*s + 1 - os];
      d = p - m;
      if (c[1]) v = (d < 0) ? 0 : d;
      else begin
        if (d > 2047)  d = 2047;
        if (d < -2048) d = -2048;
        v = (d + 4096) % 4096;
      end
    end
    return 12'(v);
  endfunction

  task automatic randomize_ch();
    for (int j = 0; j < 8; j++) ch[j] = 12'($urandom);
  endtask

  // One conversion: raise CONVST, optionally a second rise mid-conversion,
  // then drop CONVST so the part enters the read phase.
  task automatic conv(input bit early, output logic [11:0] exp);
    int lat, errs, oeh;
    m_cfg = m_next;
    exp = ref_result(m_cfg);
    m_count++;
    lat = -1; errs = 0; oeh = 0;
    adc_convst = 1'b1;
    for (int k = 1; k <= CONV + 10; k++) begin
      @(posedge clk_clk); #1;
      if (k == 5) randomize_ch();
      if (early && k == 8)  adc_convst = 1'b0;
      if (early && k == 20) adc_convst = 1'b1;
      if (lat < 0 && conv_count == 16'(m_count)) lat = k;
      if (err_early) errs++;
      if (k >= 3 && adc_sdo_oe) oeh++;
    end
    chk("conv_latency", lat, CONV + 3);
    chk("err_early_pulses", errs, early ? 1 : 0);
    chk("oe_low_in_conv", oeh, 0);
    chk("conv_count", {16'h0, conv_count}, m_count);
    chk("cfg_word", {26'h0, cfg_word}, {26'h0, m_cfg});
    adc_convst = 1'b0;
    tick(4);
    chk("oe_in_shift", {31'h0, adc_sdo_oe}, 1);
    m_next = m_cfg;
  endtask

  // Clock nsck bits out, shifting word on SDI (first six bits)
  task automatic read_frame(input logic [5:0] word, input int nsck, output logic [11:0] got);
    got = '0;
    for (int i = 0; i < nsck; i++) begin
      adc_sdi = (i < 6) ? word[5-i] : 1'($urandom);
      got[11-i] = adc_sdo;
      tick(2);
      adc_sck = 1'b1; tick(5);
      adc_sck = 1'b0; tick(5);
    end
    if (nsck == 12) chk("sdo_after_lsb", {31'h0, adc_sdo}, 0);
    if (nsck >= 6) m_next = word;
  endtask

  logic [11:0] exp, got;
  logic [5:0]  w;
  int          n;

  initial begin
    for (int j = 0; j < 8; j++) ch[j] = '0;
    tick(3);
    chk("rst_sdo", {31'h0, adc_sdo}, 0);
    chk("rst_oe", {31'h0, adc_sdo_oe}, 0);
    chk("rst_cfg", {26'h0, cfg_word}, {26'h0, DEF_CFG});
    chk("rst_count", {16'h0, conv_count}, 0);
    chk("rst_err", {31'h0, err_early}, 0);
    reset_reset = 1'b0;
    m_cfg = DEF_CFG; m_next = DEF_CFG; m_count = 0;
    tick(2);

    // Default config reads ch0 raw
    randomize_ch(); ch[0] = 12'hABC;
    conv(1'b0, exp);
    read_frame(6'b111010, 12, got);
    chk("frame_default", {20'h0, got}, {20'h0, exp});
    chk("frame_abc", {20'h0, got}, 32'hABC);

    // Config captured in frame 1 selects ch5 from frame 2 onward
    randomize_ch(); ch[5] = 12'h123;
    conv(1'b0, exp);
    read_frame(6'b111010, 12, got);
    chk("frame2_ch5", {20'h0, got}, 32'h123);
    chk("frame2_cfg", {26'h0, cfg_word}, 32'h3A);
    randomize_ch(); ch[5] = 12'h123;
    conv(1'b0, exp);
    read_frame(6'b000100, 12, got);
    chk("frame3_ch5", {20'h0, got}, 32'h123);

    // Differential bipolar saturation, both directions
    randomize_ch(); ch[2] = 12'h900; ch[3] = 12'h100;
    conv(1'b0, exp);
    read_frame(6'b000100, 12, got);
    chk("diff_sat_pos", {20'h0, got}, 32'h7FF);
    randomize_ch(); ch[2] = 12'h100; ch[3] = 12'h900;
    conv(1'b0, exp);
    read_frame(6'b000110, 12, got);
    chk("diff_neg_2048", {20'h0, got}, 32'h800);

    // Differential unipolar clamps negative to zero
    randomize_ch(); ch[2] = 12'h100; ch[3] = 12'h900;
    conv(1'b0, exp);
    read_frame(6'b000110, 12, got);
    chk("diff_uni_clamp", {20'h0, got}, 32'h000);

    // Short frame (3 SDI bits) leaves config unchanged
    randomize_ch();
    conv(1'b0, exp);
    read_frame(6'b101010, 3, got);

    // Early second CONVST rise during conversion
    randomize_ch();
    conv(1'b1, exp);
    chk("short_frame_cfg", {26'h0, cfg_word}, 32'h06);
    read_frame(6'($urandom), 12, got);
    chk("frame_after_early", {20'h0, got}, {20'h0, exp});

    // Random configs, channel data and frame lengths
    for (int it = 0; it < 14; it++) begin
      randomize_ch();
      conv(1'b0, exp);
      w = 6'($urandom);
      n = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 11)) : 12;
      read_frame(w, n, got);
      if (n == 12) chk("rand_frame", {20'h0, got}, {20'h0, exp});
    end

    // Reset in the middle of a read
    randomize_ch();
    conv(1'b0, exp);
    read_frame(6'($urandom), 5, got);
    reset_reset = 1'b1;
    @(posedge clk_clk); #1;
    chk("midrst_oe", {31'h0, adc_sdo_oe}, 0);
    chk("midrst_sdo", {31'h0, adc_sdo}, 0);
    chk("midrst_cfg", {26'h0, cfg_word}, {26'h0, DEF_CFG});
    chk("midrst_count", {16'h0, conv_count}, 0);
    tick(2);
    reset_reset = 1'b0;
    m_cfg = DEF_CFG; m_next = DEF_CFG; m_count = 0;
    tick(2);
    randomize_ch();
    conv(1'b0, exp);
    read_frame(6'($urandom), 12, got);
    chk("post_reset_frame", {20'h0, got}, {20'h0, exp});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
